// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core (IF/ID/EX/MEM/WB + ERR).
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opCode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npcMode,
    output logic        reg_we,
    output logic [1:0]  regWAMux,
    output logic [1:0]  regWDMux,
    output logic [2:0]  aluOp,
    output logic        aluSrcMux,
    output logic        extMode,
    output logic        retire,
    output logic        err,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic       r_err;

    logic w_rtype, w_add, w_sub, w_jr, w_ori, w_lui;
    logic w_lw, w_sw, w_beq, w_j, w_jal, w_nop;
    logic w_wait_hit;

    assign w_rtype = (opCode == OP_R);
    assign w_add   = w_rtype && (funct == FN_ADD);
    assign w_sub   = w_rtype && (funct == FN_SUB);
    assign w_jr    = w_rtype && (funct == FN_JR);
    assign w_ori   = (opCode == OP_ORI);
    assign w_lui   = (opCode == OP_LUI);
    assign w_lw    = (opCode == OP_LW);
    assign w_sw    = (opCode == OP_SW);
    assign w_beq   = (opCode == OP_BEQ);
    assign w_j     = (opCode == OP_J);
    assign w_jal   = (opCode == OP_JAL);
    assign w_nop   = !(w_add || w_sub || w_jr || w_ori || w_lui ||
                       w_lw || w_sw || w_beq || w_j || w_jal);

    assign w_wait_hit = (r_wait == WAIT_LAST);

    // State sequencing, memory wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_wait  <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IF, S_MEM: begin
                    if (mem_ack) begin
                        r_wait <= 8'd0;
                        if (r_state == S_IF)
                            r_state <= S_ID;
                        else if (w_lw)
                            r_state <= S_WB;
                        else
                            r_state <= S_IF;
                    end else if (w_wait_hit) begin
                        r_wait  <= 8'd0;
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_ID: begin
                    if (w_j || w_jal || w_jr || w_nop)
                        r_state <= S_IF;
                    else
                        r_state <= S_EX;
                end
                S_EX: begin
                    if (w_lw || w_sw)
                        r_state <= S_MEM;
                    else if (w_beq || w_nop)
                        r_state <= S_IF;
                    else
                        r_state <= S_WB;
                end
                S_WB:    r_state <= S_IF;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IF;
            endcase
        end
    end

    // Per-state enables and mux selects; everything held at 0 during reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npcMode   = 2'd0;
        reg_we    = 1'b0;
        regWAMux  = 2'd0;
        regWDMux  = 2'd0;
        aluOp     = reset ? 3'd0 : 3'd7;
        aluSrcMux = 1'b0;
        extMode   = 1'b0;
        retire    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IF: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                S_ID: begin
                    if (w_j || w_jal) begin
                        pc_we   = 1'b1;
                        npcMode = 2'd2;
                        retire  = 1'b1;
                    end
                    if (w_jal) begin
                        reg_we   = 1'b1;
                        regWAMux = 2'd2;
                        regWDMux = 2'd2;
                    end
                    if (w_jr) begin
                        pc_we   = 1'b1;
                        npcMode = 2'd3;
                        retire  = 1'b1;
                    end
                    if (w_nop)
                        retire = 1'b1;
                end
                S_EX: begin
                    if (w_beq) begin
                        aluOp   = 3'd1;
                        pc_we   = zero;
                        npcMode = 2'd1;
                        retire  = 1'b1;
                    end else if (w_lw || w_sw) begin
                        aluOp     = 3'd0;
                        aluSrcMux = 1'b1;
                        extMode   = 1'b1;
                    end else if (w_add) begin
                        aluOp = 3'd0;
                    end else if (w_sub) begin
                        aluOp = 3'd1;
                    end else if (w_ori) begin
                        aluOp     = 3'd2;
                        aluSrcMux = 1'b1;
                    end else if (w_lui) begin
                        aluOp     = 3'd3;
                        aluSrcMux = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = w_sw;
                    aluOp     = 3'd0;
                    aluSrcMux = 1'b1;
                    extMode   = 1'b1;
                    retire    = mem_ack && w_sw;
                end
                S_WB: begin
                    reg_we   = 1'b1;
                    retire   = 1'b1;
                    regWAMux = (w_add || w_sub) ? 2'd1 : 2'd0;
                    regWDMux = w_lw ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign err   = reset ? 1'b0 : r_err;
    assign state = reset ? 3'd0 : r_state;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] r_instr_cnt;

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_instr_cnt <= 32'd0;
        else if (retire)
            r_instr_cnt <= r_instr_cnt + 32'd1;
    end

    assign instr_cnt = reset ? 32'd0 : r_instr_cnt;
`else
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl.
// Expected per-cycle outputs come from an instruction-level trace model.
module tb_multicycle_ctrl;

    localparam int MAXW = 15;

    localparam int C_ADD = 0;
    localparam int C_SUB = 1;
    localparam int C_ORI = 2;
    localparam int C_LUI = 3;
    localparam int C_LW  = 4;
    localparam int C_SW  = 5;
    localparam int C_BEQ = 6;
    localparam int C_J   = 7;
    localparam int C_JAL = 8;
    localparam int C_JR  = 9;
    localparam int C_NOP = 10;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       irwe;
        logic       pcwe;
        logic [1:0] npc;
        logic       rwe;
        logic [1:0] wa;
        logic [1:0] wd;
        logic [2:0] alu;
        logic       src;
        logic       ext;
        logic       ret;
        logic       err;
    } exp_t;

    typedef struct {
        exp_t e;
        logic ack;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opCode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npcMode;
    logic        reg_we;
    logic [1:0]  regWAMux;
    logic [1:0]  regWDMux;
    logic [2:0]  aluOp;
    logic        aluSrcMux;
    logic        extMode;
    logic        retire;
    logic        err;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int    errors = 0;
    int    checks = 0;
    int    mcnt   = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .opCode    (opCode),
        .funct     (funct),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .npcMode   (npcMode),
        .reg_we    (reg_we),
        .regWAMux  (regWAMux),
        .regWDMux  (regWDMux),
        .aluOp     (aluOp),
        .aluSrcMux (aluSrcMux),
        .extMode   (extMode),
        .retire    (retire),
        .err       (err),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ecnt();
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        return 32'(mcnt);
`else
        return 32'd0;
`endif
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.st   = state;
        o.req  = mem_req;
        o.we   = mem_we;
        o.irwe = ir_we;
        o.pcwe = pc_we;
        o.npc  = npcMode;
        o.rwe  = reg_we;
        o.wa   = regWAMux;
        o.wd   = regWDMux;
        o.alu  = aluOp;
        o.src  = aluSrcMux;
        o.ext  = extMode;
        o.ret  = retire;
        o.err  = err;
        return o;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.alu = 3'd7;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic enc(input int c, output logic [5:0] op,
                       output logic [5:0] fn);
        fn = 6'($urandom);
        case (c)
            C_ADD: begin op = 6'h00; fn = 6'h20; end
            C_SUB: begin op = 6'h00; fn = 6'h22; end
            C_JR:  begin op = 6'h00; fn = 6'h08; end
            C_ORI: op = 6'h0d;
            C_LUI: op = 6'h0f;
            C_LW:  op = 6'h23;
            C_SW:  op = 6'h2b;
            C_BEQ: op = 6'h04;
            C_J:   op = 6'h02;
            C_JAL: op = 6'h03;
            default: begin
                if (rb()) op = 6'h3f;
                else begin op = 6'h00; fn = 6'h21; end
            end
        endcase
    endtask

    task automatic add_err();
        step_t s;
        for (int k = 0; k < 3; k++) begin
            s.e     = base(3'd7);
            s.e.err = 1'b1;
            s.ack   = rb();
            q.push_back(s);
        end
    endtask

    // Expected cycle-by-cycle trace of one instruction.
    // A wait of MAXW or more means the memory never answers.
    task automatic build(input int c, input int ifw, input int mw,
                         input logic z);
        step_t s;
        int    n;
        n = (ifw >= MAXW) ? MAXW : ifw + 1;
        for (int w = 0; w < n; w++) begin
            s.e      = base(3'd0);
            s.e.req  = 1'b1;
            s.ack    = (w == ifw);
            s.e.irwe = s.ack;
            s.e.pcwe = s.ack;
            q.push_back(s);
        end
        if (ifw >= MAXW) begin
            add_err();
            return;
        end
        s.e   = base(3'd1);
        s.ack = rb();
        case (c)
            C_J:   begin s.e.pcwe = 1; s.e.npc = 2; s.e.ret = 1; end
            C_JAL: begin
                s.e.pcwe = 1; s.e.npc = 2; s.e.ret = 1;
                s.e.rwe = 1; s.e.wa = 2; s.e.wd = 2;
            end
            C_JR:  begin s.e.pcwe = 1; s.e.npc = 3; s.e.ret = 1; end
            C_NOP: s.e.ret = 1;
            default: ;
        endcase
        q.push_back(s);
        if (s.e.ret) return;
        s.e   = base(3'd2);
        s.ack = rb();
        case (c)
            C_ADD: s.e.alu = 0;
            C_SUB: s.e.alu = 1;
            C_ORI: begin s.e.alu = 2; s.e.src = 1; end
            C_LUI: begin s.e.alu = 3; s.e.src = 1; end
            C_BEQ: begin
                s.e.alu = 1; s.e.pcwe = z; s.e.npc = 1; s.e.ret = 1;
            end
            default: begin s.e.alu = 0; s.e.src = 1; s.e.ext = 1; end
        endcase
        q.push_back(s);
        if (s.e.ret) return;
        if (c == C_LW || c == C_SW) begin
            n = (mw >= MAXW) ? MAXW : mw + 1;
            for (int w = 0; w < n; w++) begin
                s.e     = base(3'd3);
                s.e.req = 1'b1;
                s.e.we  = (c == C_SW);
                s.e.alu = 0;
                s.e.src = 1;
                s.e.ext = 1;
                s.ack   = (w == mw);
                s.e.ret = s.ack && (c == C_SW);
                q.push_back(s);
            end
            if (mw >= MAXW) begin
                add_err();
                return;
            end
            if (c == C_SW) return;
        end
        s.e     = base(3'd4);
        s.ack   = rb();
        s.e.rwe = 1;
        s.e.ret = 1;
        s.e.wa  = (c == C_ADD || c == C_SUB) ? 2'd1 : 2'd0;
        s.e.wd  = (c == C_LW) ? 2'd1 : 2'd0;
        q.push_back(s);
    endtask

    // Plays one instruction; rst_mem>0 asserts reset in that MEM cycle
    task automatic run(input int c, input int ifw, input int mw,
                       input logic z, input int rst_mem);
        logic [5:0] op;
        logic [5:0] fn;
        step_t      s;
        int         nmem;
        nmem = 0;
        enc(c, op, fn);
        build(c, ifw, mw, z);
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            if (s.e.st == 3'd0) begin
                opCode = 6'($urandom);
                funct  = 6'($urandom);
            end else begin
                opCode = op;
                funct  = fn;
            end
            zero    = z;
            mem_ack = s.ack;
            #1;
            chk("outs", {11'b0, obs()}, {11'b0, s.e});
            chk("cnt", instr_cnt, ecnt());
            if (s.e.st == 3'd3) nmem++;
            if (rst_mem != 0 && nmem == rst_mem) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_outs", {11'b0, obs()}, 32'd0);
                chk("rst_cnt", instr_cnt, 32'd0);
                mcnt = 0;
                q.delete();
            end else if (s.e.ret) begin
                mcnt++;
            end
        end
    endtask

    // Holds reset across a clock edge, then releases it into IF
    task automatic do_reset();
        @(negedge clk);
        mem_ack = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_hold", {11'b0, obs()}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_edge", {11'b0, obs()}, 32'd0);
        chk("rst_cnt0", instr_cnt, 32'd0);
        reset = 1'b0;
        mcnt  = 0;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_req", 32'(mem_req), 32'd1);
        chk("rel_err", 32'(err), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        opCode  = 6'd0;
        funct   = 6'd0;
        zero    = 1'b0;
        mem_ack = 1'b0;
        do_reset();

        run(C_ADD, 0, 0, 1'b0, 0);
        run(C_LW,  3, 3, 1'b0, 0);
        run(C_BEQ, 0, 0, 1'b1, 0);
        run(C_BEQ, 0, 0, 1'b0, 0);
        run(C_JAL, 0, 0, 1'b0, 0);
        run(C_J,   1, 0, 1'b0, 0);
        run(C_JR,  0, 0, 1'b1, 0);
        run(C_NOP, 2, 0, 1'b0, 0);
        run(C_SUB, 0, 0, 1'b0, 0);
        run(C_ORI, 0, 0, 1'b1, 0);
        run(C_LUI, 0, 0, 1'b0, 0);
        run(C_SW,  0, 2, 1'b0, 0);
        run(C_LW, 14, 14, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            int c;
            int ifw;
            int mw;
            c   = $urandom_range(0, 10);
            ifw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            mw  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            run(c, ifw, mw, rb(), 0);
        end

        run(C_SW, 0, 5, 1'b0, 2);
        @(negedge clk);
        #1;
        chk("rst_mid", {11'b0, obs()}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rel_state", 32'(state), 32'd0);
        chk("mid_rel_req", 32'(mem_req), 32'd1);
        run(C_ADD, 0, 0, 1'b0, 0);

        run(C_ADD, MAXW, 0, 1'b0, 0);
        do_reset();
        run(C_ORI, 0, 0, 1'b0, 0);
        run(C_LW, 1, MAXW, 1'b0, 0);
        do_reset();
        run(C_SW, 0, 0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
